// File: rtl/netbus_arb7_if.sv
// netbus_arb7_if: NetBus signal bundle around the 7:1 arbiter.
// The master modport is the arbiter's view; slave is the surrounding hub/bench.
interface netbus_arb7_if #(
  parameter int DATA_WIDTH = 4
) ();
  localparam int W = DATA_WIDTH*9+14;

  logic [7*W-1:0] IN_DATA;
  logic [6:0]     IN_VALID;
  logic [6:0]     IN_READY;
  logic [W-1:0]   OUT_DATA;
  logic           OUT_VALID;
  logic           OUT_READY;
  logic [6:0]     GRANT;
  logic           ERR_TIMEOUT;

  modport master (
    input  IN_DATA, IN_VALID, OUT_READY,
    output IN_READY, OUT_DATA, OUT_VALID, GRANT, ERR_TIMEOUT
  );

  modport slave (
    output IN_DATA, IN_VALID, OUT_READY,
    input  IN_READY, OUT_DATA, OUT_VALID, GRANT, ERR_TIMEOUT
  );
endinterface

// File: rtl/netbus_arb7.sv
// netbus_arb7: packet-aware 7:1 NetBus arbiter, RT ports first, round-robin per class.
// Define NETBUS_ARB_TIMEOUT_EN to release a lock stalled for TIMEOUT cycles.
module netbus_arb7 #(
  parameter int         DATA_WIDTH = 4,
  parameter int         LAST_BIT   = DATA_WIDTH*9+13,
  parameter logic [6:0] RT_MASK    = 7'b0000000,
  parameter int         MAX_WAIT   = 8,
  parameter int         TIMEOUT    = 255
) (
  input logic           CLK,
  input logic           RESETn,
  netbus_arb7_if.master bus
);
  localparam int         W          = DATA_WIDTH*9+14;
  localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

  typedef enum logic {IDLE, LOCK} state_t;

  state_t         state, next_state;
  logic [6:0]     grant;
  logic [2:0]     owner;
  logic [2:0]     rr_ptr_rt, rr_ptr_nrt;
  logic [7:0]     wait_cnt [7];
  logic           out_valid;
  logic [W-1:0]   out_data;

  logic           load_ok, xfer, last_beat, any_valid;
  logic           do_grant, release_lock, timeout_hit, found;
  logic [6:0]     in_ready;
  logic [W-1:0]   sel_data;
  logic [2:0]     winner, idx, next_ptr;

  function automatic logic [2:0] wrap7(input logic [3:0] v);
    return (v >= 4'd7) ? 3'(v - 4'd7) : v[2:0];
  endfunction

  always_comb begin
    load_ok   = !out_valid || bus.OUT_READY;
    in_ready  = (state == LOCK && load_ok) ? grant : 7'd0;
    any_valid = |bus.IN_VALID;
    xfer      = |(bus.IN_VALID & in_ready);
    sel_data  = '0;
    for (int i = 0; i < 7; i++) begin
      if (owner == 3'(i)) sel_data = bus.IN_DATA[i*W +: W];
    end
    last_beat = sel_data[LAST_BIT];
    next_ptr  = (owner == 3'd6) ? 3'd0 : owner + 3'd1;
  end

  // Winner: starved non-RT port first, then RT round-robin, then non-RT round-robin.
  always_comb begin
    found  = 1'b0;
    winner = 3'd0;
    idx    = 3'd0;
    if (MAX_WAIT != 0) begin
      for (int i = 0; i < 7; i++) begin
        if (!found && !RT_MASK[i] && bus.IN_VALID[i] && wait_cnt[i] >= WAIT_LIMIT) begin
          found  = 1'b1;
          winner = 3'(i);
        end
      end
    end
    for (int k = 0; k < 7; k++) begin
      idx = wrap7({1'b0, rr_ptr_rt} + 4'(k));
      if (!found && RT_MASK[idx] && bus.IN_VALID[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
    for (int k = 0; k < 7; k++) begin
      idx = wrap7({1'b0, rr_ptr_nrt} + 4'(k));
      if (!found && !RT_MASK[idx] && bus.IN_VALID[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  always_comb begin
    next_state   = state;
    do_grant     = 1'b0;
    release_lock = 1'b0;
    case (state)
      IDLE: begin
        if (any_valid) begin
          next_state = LOCK;
          do_grant   = 1'b1;
        end
      end
      LOCK: begin
        if ((xfer && last_beat) || timeout_hit) begin
          next_state   = IDLE;
          release_lock = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) state <= IDLE;
    else         state <= next_state;
  end

  // Grant ownership, class pointers and the starvation counters of non-RT ports.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      grant      <= '0;
      owner      <= '0;
      rr_ptr_rt  <= '0;
      rr_ptr_nrt <= '0;
      for (int i = 0; i < 7; i++) wait_cnt[i] <= '0;
    end else if (do_grant) begin
      grant <= 7'd1 << winner;
      owner <= winner;
      for (int i = 0; i < 7; i++) begin
        if (!RT_MASK[i]) begin
          if (winner == 3'(i))
            wait_cnt[i] <= '0;
          else if (bus.IN_VALID[i] && wait_cnt[i] != 8'hFF)
            wait_cnt[i] <= wait_cnt[i] + 8'd1;
        end
      end
    end else if (release_lock) begin
      grant <= '0;
      if (RT_MASK[owner]) rr_ptr_rt  <= next_ptr;
      else                rr_ptr_nrt <= next_ptr;
    end
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= sel_data;
    end else if (bus.OUT_READY) begin
      out_valid <= 1'b0;
    end
  end

`ifdef NETBUS_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT+1);

  logic [TW-1:0] stall_cnt;
  logic          stalled;
  logic          err_q;

  always_comb begin
    stalled     = (state == LOCK) && !(|(bus.IN_VALID & grant));
    timeout_hit = stalled && (stall_cnt == TW'(TIMEOUT - 1));
  end

  // Counts cycles the owner leaves its valid low; any transfer restarts it.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      stall_cnt <= '0;
      err_q     <= 1'b0;
    end else begin
      err_q <= timeout_hit;
      if (state != LOCK || xfer || timeout_hit) stall_cnt <= '0;
      else if (stalled)                         stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign bus.ERR_TIMEOUT = err_q;
`else
  assign timeout_hit     = 1'b0;
  assign bus.ERR_TIMEOUT = 1'b0;
`endif

  assign bus.IN_READY  = in_ready;
  assign bus.GRANT     = grant;
  assign bus.OUT_VALID = out_valid;
  assign bus.OUT_DATA  = out_data;

endmodule

// File: tb/tb_netbus_arb7.sv
// tb_netbus_arb7: random and directed packet traffic against a per-cycle arbitration model.
// Configuration under test: port 2 real-time, starvation limit of 3 lost rounds.
module tb_netbus_arb7;
  localparam int         DW   = 4;
  localparam int         W    = DW*9+14;
  localparam int         LB   = DW*9+13;
  localparam logic [6:0] RTM  = 7'b0000100;
  localparam int         MAXW = 3;

  logic clk;
  logic rst_n;

  netbus_arb7_if #(.DATA_WIDTH(DW)) bus ();

  netbus_arb7 #(
    .DATA_WIDTH(DW),
    .RT_MASK(RTM),
    .MAX_WAIT(MAXW)
  ) dut (
    .CLK(clk),
    .RESETn(rst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total, bad;
  int owner, ptr_rt, ptr_nrt, out_cnt;
  int waitc [7];
  int vprob [7];
  int head [7];
  int tail [7];
  logic [W-1:0] mem [7][64];
  logic         exp_ov;
  logic [W-1:0] exp_od;
  logic [6:0]   prev_grant;
  logic [6:0]   gtrace [$];
  logic [6:0]   gorder [$];
  logic         ovtrace [$];
  logic [6:0]   expb [10] = '{7'h04, 7'h04, 7'h04, 7'h02, 7'h04, 7'h04, 7'h04, 7'h02, 7'h04, 7'h04};

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    owner      = -1;
    ptr_rt     = 0;
    ptr_nrt    = 0;
    exp_ov     = 1'b0;
    exp_od     = '0;
    prev_grant = '0;
    for (int i = 0; i < 7; i++) waitc[i] = 0;
  endtask

  task automatic clearSources();
    for (int i = 0; i < 7; i++) begin
      head[i]  = 0;
      tail[i]  = 0;
      vprob[i] = 100;
    end
  endtask

  task automatic addPacket(input int p, input int len);
    logic [63:0] r;
    for (int b = 0; b < len; b++) begin
      r     = {$urandom, $urandom};
      r[LB] = (b == len-1);
      mem[p][tail[p]] = r[W-1:0];
      tail[p]++;
    end
  endtask

  function automatic int pickWinner(input logic [6:0] v);
    int k;
    for (int i = 0; i < 7; i++)
      if (MAXW != 0 && !RTM[i] && v[i] && waitc[i] >= MAXW) return i;
    for (int j = 0; j < 7; j++) begin
      k = (ptr_rt + j) % 7;
      if (RTM[k] && v[k]) return k;
    end
    for (int j = 0; j < 7; j++) begin
      k = (ptr_nrt + j) % 7;
      if (!RTM[k] && v[k]) return k;
    end
    return -1;
  endfunction

  function automatic bit idleModel();
    for (int i = 0; i < 7; i++) if (head[i] < tail[i]) return 1'b0;
    return (owner < 0) && !exp_ov;
  endfunction

  // One clock: drive at the falling edge, check just after, advance the model over the rising edge.
  task automatic applyStimulus(input logic rdy);
    logic [6:0]   v, exp_grant, exp_ready;
    logic [63:0]  r;
    logic         load_ok;
    int           win;
    v = '0;
    for (int i = 0; i < 7; i++) begin
      r = {$urandom, $urandom};
      if (head[i] < tail[i]) begin
        bus.IN_DATA[i*W +: W] = mem[i][head[i]];
        if ($urandom_range(99) < vprob[i]) v[i] = 1'b1;
      end else begin
        bus.IN_DATA[i*W +: W] = r[W-1:0];
      end
    end
    bus.IN_VALID  = v;
    bus.OUT_READY = rdy;
    #1;
    exp_grant = (owner >= 0) ? 7'(1 << owner) : 7'd0;
    load_ok   = !exp_ov || rdy;
    exp_ready = (owner >= 0 && load_ok) ? exp_grant : 7'd0;
    checkOutput("grant", bus.GRANT, exp_grant);
    checkOutput("in_ready", bus.IN_READY, exp_ready);
    checkOutput("out_valid", bus.OUT_VALID, exp_ov);
    if (exp_ov) checkOutput("out_data", bus.OUT_DATA, exp_od);
    checkOutput("err_timeout", bus.ERR_TIMEOUT, 1'b0);
    gtrace.push_back(bus.GRANT);
    ovtrace.push_back(bus.OUT_VALID);
    if (prev_grant == 7'd0 && bus.GRANT != 7'd0) gorder.push_back(bus.GRANT);
    prev_grant = bus.GRANT;
    if (bus.OUT_VALID && rdy) out_cnt++;
    if (owner >= 0) begin
      if (v[owner] && load_ok) begin
        exp_od = bus.IN_DATA[owner*W +: W];
        exp_ov = 1'b1;
        if (exp_od[LB]) begin
          if (RTM[owner]) ptr_rt  = (owner + 1) % 7;
          else            ptr_nrt = (owner + 1) % 7;
          owner = -1;
        end
      end else if (rdy) begin
        exp_ov = 1'b0;
      end
    end else begin
      if (rdy) exp_ov = 1'b0;
      if (v != 7'd0) begin
        win = pickWinner(v);
        for (int i = 0; i < 7; i++) begin
          if (!RTM[i]) begin
            if (i == win)  waitc[i] = 0;
            else if (v[i]) waitc[i]++;
          end
        end
        owner = win;
      end
    end
    for (int i = 0; i < 7; i++)
      if (v[i] && bus.IN_READY[i]) head[i]++;
    @(negedge clk);
  endtask

  task automatic drain(input int bound, input int rprob);
    int n;
    bit done;
    n = 0;
    do begin
      applyStimulus($urandom_range(99) < rprob);
      n++;
      done = idleModel();
    end while (!done && n < bound);
    checkOutput("drain", done, 1'b1);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base, beats;
    logic [W-1:0] held;
    total = 0;
    bad   = 0;
    out_cnt = 0;
    rst_n = 1'b0;
    bus.IN_VALID  = 7'h55;
    bus.IN_DATA   = '0;
    bus.OUT_READY = 1'b1;
    modelReset();
    clearSources();
    #12;
    checkOutput("rst_grant", bus.GRANT, 7'd0);
    checkOutput("rst_out_valid", bus.OUT_VALID, 1'b0);
    checkOutput("rst_out_data", bus.OUT_DATA, '0);
    checkOutput("rst_in_ready", bus.IN_READY, 7'd0);
    bus.IN_VALID = '0;
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b1);

    // Three simultaneous non-RT packets leave in index order with one bubble between them.
    gorder.delete(); gtrace.delete(); ovtrace.delete();
    addPacket(0, 3); addPacket(3, 3); addPacket(5, 3);
    drain(200, 100);
    checkOutput("a_count", gorder.size(), 3);
    checkOutput("a_first", (gorder.size() > 0) ? gorder[0] : 7'h7f, 7'h01);
    checkOutput("a_second", (gorder.size() > 1) ? gorder[1] : 7'h7f, 7'h08);
    checkOutput("a_third", (gorder.size() > 2) ? gorder[2] : 7'h7f, 7'h20);
    checkOutput("a_lat1", (ovtrace.size() > 1) ? ovtrace[1] : 1'bx, 1'b0);
    checkOutput("a_lat2", (ovtrace.size() > 2) ? ovtrace[2] : 1'bx, 1'b1);
    checkOutput("a_gap1", (ovtrace.size() > 5) ? ovtrace[5] : 1'bx, 1'b0);
    checkOutput("a_gap2", (ovtrace.size() > 9) ? ovtrace[9] : 1'bx, 1'b0);
    checkOutput("a_lastout", (ovtrace.size() > 12) ? ovtrace[12] : 1'bx, 1'b1);

    // RT port 2 always wins except when port 1 has lost three decisions.
    clearSources(); gorder.delete();
    for (int i = 0; i < 8; i++) addPacket(2, 2);
    addPacket(1, 2); addPacket(1, 2);
    drain(400, 100);
    checkOutput("b_count", gorder.size(), 10);
    for (int i = 0; i < 10; i++)
      checkOutput($sformatf("b_grant%0d", i), (i < gorder.size()) ? gorder[i] : 7'h7f, expb[i]);

    // Downstream stall mid-packet: output frozen, input not drained, nothing lost.
    clearSources();
    base = out_cnt;
    addPacket(6, 4);
    repeat (3) applyStimulus(1'b1);
    held = bus.OUT_DATA;
    repeat (5) begin
      applyStimulus(1'b0);
      checkOutput("c_hold_data", bus.OUT_DATA, held);
      checkOutput("c_hold_valid", bus.OUT_VALID, 1'b1);
      checkOutput("c_in_ready", bus.IN_READY, 7'd0);
    end
    drain(50, 100);
    checkOutput("c_beats", out_cnt - base, 4);

    // Single-beat packet on port 4, then port 6 asks while 4 still holds the lock.
    clearSources(); gtrace.delete();
    addPacket(4, 1);
    applyStimulus(1'b1);
    addPacket(6, 2);
    drain(50, 100);
    checkOutput("d_c0", (gtrace.size() > 0) ? gtrace[0] : 7'h7f, 7'h00);
    checkOutput("d_c1", (gtrace.size() > 1) ? gtrace[1] : 7'h7f, 7'h10);
    checkOutput("d_c2", (gtrace.size() > 2) ? gtrace[2] : 7'h7f, 7'h00);
    checkOutput("d_c3", (gtrace.size() > 3) ? gtrace[3] : 7'h7f, 7'h40);

    // Random traffic on every port with bursty valids and downstream backpressure.
    clearSources();
    base  = out_cnt;
    beats = 0;
    for (int p = 0; p < 7; p++) begin
      vprob[p] = $urandom_range(40, 100);
      for (int k = 0; k < 4; k++) begin
        int len;
        len = $urandom_range(1, 4);
        beats += len;
        addPacket(p, len);
      end
    end
    drain(3000, 70);
    checkOutput("e_beats", out_cnt - base, beats);

    // Reset in the middle of a packet drops it entirely.
    clearSources();
    addPacket(0, 5);
    repeat (3) applyStimulus(1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("f_out_valid", bus.OUT_VALID, 1'b0);
    checkOutput("f_out_data", bus.OUT_DATA, '0);
    checkOutput("f_grant", bus.GRANT, 7'd0);
    checkOutput("f_in_ready", bus.IN_READY, 7'd0);
    bus.IN_VALID = '0;
    modelReset();
    clearSources();
    @(negedge clk);
    rst_n = 1'b1;
    addPacket(3, 2);
    drain(50, 100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
